regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file: two write-back ports (E, M), two read ports (A, B).
//  Per-register busy scoreboard: decode claims a destination; write-back releases it.
//  Sits between decode (reads, claims) and the execute/memory write-back stages.
//  Flat debug bus exposes every register to the testbench and top level.
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  8   number of architectural registers, 2..(2**ADDR_W - 1)
//  ADDR_W    4   register-ID width; the all-ones ID (RNONE, 4'hF) means "no register"
// PORTS
//  clock       in   1                  rising-edge clock
//  reset       in   1                  synchronous, active-high; sampled on posedge clock only
//  dstE        in   ADDR_W             E write-back register ID
//  valE        in   DATA_W             E write-back data
//  dstM        in   ADDR_W             M write-back register ID
//  valM        in   DATA_W             M write-back data
//  srcA        in   ADDR_W             read port A register ID
//  srcB        in   ADDR_W             read port B register ID
//  claim_en    in   1                  mark claim_dst busy
//  claim_dst   in   ADDR_W             register claimed by the instruction in decode
//  valA        out  DATA_W             read data, port A (combinational)
//  valB        out  DATA_W             read data, port B (combinational)
//  stallA      out  1                  port A source busy, valA not usable
//  stallB      out  1                  port B source busy, valB not usable
//  busy        out  NUM_REGS           scoreboard vector, bit i = register i busy
//  regs_flat   out  NUM_REGS*DATA_W    register i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: all registers 0, busy 0. stall*, valA and valB read 0.
//  - Reset wins over any same-cycle write or claim. Mid-operation reset discards in-flight claims.
//  - Writes: on posedge, reg[dstE]<=valE and reg[dstM]<=valM when the ID < NUM_REGS.
//  - RNONE or any ID >= NUM_REGS: write, claim or release ignored; no state change.
//  - dstE==dstM (valid ID): M wins; valE discarded.
//  - Reads: valX = reg[srcX], zero-cycle latency. srcX invalid -> valX=0, stallX=0.
//  - Scoreboard, per register i, evaluated on posedge:
//      set   = claim_en && claim_dst==i
//      clear = (dstE==i) || (dstM==i)
//      busy_next = set ? 1 : (clear ? 0 : busy)
//    Claim and release of the same register in one cycle: busy stays 1 (new producer in flight).
//    Claiming an already-busy register is legal; busy stays 1. There is no per-register count.
//  - stallX = busy[srcX] && !hitX, where hitX is defined only with bypass enabled (else 0).
//  - Reads never depend on claim_en or claim_dst in the same cycle.
//  - Widths: no arithmetic; data passes through unmodified. ID compares use full ADDR_W.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - hitX = srcX valid && (srcX==dstM || srcX==dstE).
//    - On a hit, valX returns the incoming write data (valM has priority over valE); stallX=0.
//    - Net effect: a read in the same cycle as its write sees the new value.
//  REGFILE_BYPASS_EN undefined:
//    - hitX=0; valX returns the stored value only.
//    - A register written at edge N is readable, and unstalled, from cycle N+1.
// TESTING
//  1 reset=1 for 2 cycles, dstE=0,valE=32'hABCDEF98 -> all regs 0, busy=0 after the edge.
//  2 dstE=0,valE=32'hABCDEF98; dstM=1,valM=32'h7654321A -> next cycle srcA=0 gives ABCDEF98, srcB=1 gives 7654321A.
//  3 dstE=dstM=3, valE=32'h11111111, valM=32'h22222222 -> reg3=22222222.
//  4 dstE=4'hF / dstM=4'h9 (NUM_REGS=8), claim_dst=4'hF -> regs_flat and busy unchanged.
//  5 claim 5; next cycle srcA=5 -> stallA=1. dstE=5,valE=32'h5A5A5A5A:
//      bypass on  -> same cycle valA=5A5A5A5A, stallA=0
//      bypass off -> stallA=1 this cycle; next cycle valA=5A5A5A5A, stallA=0
//  6 claim 6 and dstM=6 in the same cycle -> busy[6]=1 after the edge. Then reset mid-stream -> busy=0, regs 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus between decode/write-back and the multi-port register file, plus the debug view.
interface regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4
);
  logic [ADDR_W-1:0]          dstE, dstM, srcA, srcB, claim_dst;
  logic [DATA_W-1:0]          valE, valM, valA, valB;
  logic                       claim_en, stallA, stallB;
  logic [NUM_REGS-1:0]        busy;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  modport master (
    output dstE, valE, dstM, valM, srcA, srcB, claim_en, claim_dst,
    input  valA, valB, stallA, stallB, busy, regs_flat
  );
  modport slave (
    input  dstE, valE, dstM, valM, srcA, srcB, claim_en, claim_dst,
    output valA, valB, stallA, stallB, busy, regs_flat
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4
) (
  input logic         clock,
  input logic         reset,
  regfile_mp_if.slave rf
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busyQ;

  // IDs at or above NUM_REGS (including the all-ones "no register" ID) are inert.
  function automatic logic idOk(input logic [ADDR_W-1:0] id);
    return int'(id) < NUM_REGS;
  endfunction

  logic wrE, wrM;
  assign wrE = idOk(rf.dstE);
  assign wrM = idOk(rf.dstM);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busyQ <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        logic hitE, hitM, setB;
        hitE = wrE && (rf.dstE == ADDR_W'(i));
        hitM = wrM && (rf.dstM == ADDR_W'(i));
        setB = rf.claim_en && (rf.claim_dst == ADDR_W'(i));
        // M overrides E on a same-register collision
        if (hitM)      regs[i] <= rf.valM;
        else if (hitE) regs[i] <= rf.valE;
        // A fresh claim outranks a release: a new producer is in flight.
        if (setB)              busyQ[i] <= 1'b1;
        else if (hitE || hitM) busyQ[i] <= 1'b0;
      end
    end
  end

  logic [1:0][ADDR_W-1:0] src;
  logic [1:0][DATA_W-1:0] rdVal;
  logic [1:0]             rdStall;
  assign src = {rf.srcB, rf.srcA};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdVal[p]   = '0;
      rdStall[p] = 1'b0;
      if (idOk(src[p])) begin
        rdVal[p]   = regs[src[p][IDX_W-1:0]];
        rdStall[p] = busyQ[src[p][IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (src[p] == rf.dstM) begin
          rdVal[p]   = rf.valM;
          rdStall[p] = 1'b0;
        end else if (src[p] == rf.dstE) begin
          rdVal[p]   = rf.valE;
          rdStall[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign rf.valA   = rdVal[0];
  assign rf.valB   = rdVal[1];
  assign rf.stallA = rdStall[0];
  assign rf.stallB = rdStall[1];
  assign rf.busy   = busyQ;

  for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
    assign rf.regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule
